// File: rtl/exc_pkg.sv
// Shared encodings for the exception entry controller: exception indices,
// processor modes, vector offsets and sequencer states.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_VECTOR = 2'd2
  } exc_state_e;

  localparam int EXC_DABT = 0;
  localparam int EXC_FIQ  = 1;
  localparam int EXC_IRQ  = 2;
  localparam int EXC_PABT = 3;
  localparam int EXC_UND  = 4;
  localparam int EXC_SVC  = 5;

  localparam logic [5:0] GNT_DABT = 6'b000001 << EXC_DABT;
  localparam logic [5:0] GNT_FIQ  = 6'b000001 << EXC_FIQ;
  localparam logic [5:0] GNT_IRQ  = 6'b000001 << EXC_IRQ;
  localparam logic [5:0] GNT_PABT = 6'b000001 << EXC_PABT;
  localparam logic [5:0] GNT_UND  = 6'b000001 << EXC_UND;
  localparam logic [5:0] GNT_SVC  = 6'b000001 << EXC_SVC;

  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  localparam logic [31:0] VOFF_UND  = 32'h0000_0004;
  localparam logic [31:0] VOFF_SVC  = 32'h0000_0008;
  localparam logic [31:0] VOFF_PABT = 32'h0000_000C;
  localparam logic [31:0] VOFF_DABT = 32'h0000_0010;
  localparam logic [31:0] VOFF_IRQ  = 32'h0000_0018;
  localparam logic [31:0] VOFF_FIQ  = 32'h0000_001C;

  localparam logic [3:0] LR_ADDR = 4'd14;

  function automatic logic [4:0] target_mode(input logic [5:0] grant);
    logic [4:0] m;
    case (grant)
      GNT_DABT: m = MODE_ABT;
      GNT_FIQ:  m = MODE_FIQ;
      GNT_IRQ:  m = MODE_IRQ;
      GNT_PABT: m = MODE_ABT;
      GNT_UND:  m = MODE_UND;
      GNT_SVC:  m = MODE_SVC;
      default:  m = MODE_SVC;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] vec_offset(input logic [5:0] grant);
    logic [31:0] o;
    case (grant)
      GNT_DABT: o = VOFF_DABT;
      GNT_FIQ:  o = VOFF_FIQ;
      GNT_IRQ:  o = VOFF_IRQ;
      GNT_PABT: o = VOFF_PABT;
      GNT_UND:  o = VOFF_UND;
      GNT_SVC:  o = VOFF_SVC;
      default:  o = 32'h0000_0000;
    endcase
    return o;
  endfunction

  // Data aborts return past the faulting instruction plus one more word.
  function automatic logic [31:0] ret_offset(input logic [5:0] grant);
    logic [31:0] o;
    if (grant == GNT_DABT) begin
      o = 32'd8;
    end else begin
      o = 32'd4;
    end
    return o;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Masks irq/fiq with the CPSR I/F bits and grants the highest-priority
// remaining request as a one-hot vector.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [5:0] req,
  input  logic       irq_mask,
  input  logic       fiq_mask,
  output logic [5:0] grant,
  output logic       valid
);

  logic [5:0] masked_s;

  // Only irq and fiq are maskable.
  always_comb begin
    masked_s          = req;
    masked_s[EXC_IRQ] = req[EXC_IRQ] & ~irq_mask;
    masked_s[EXC_FIQ] = req[EXC_FIQ] & ~fiq_mask;
  end

  // Fixed priority: dabt > fiq > irq > pabt > und > svc.
  always_comb begin
    grant = 6'b000000;
    if (masked_s[EXC_DABT]) begin
      grant = GNT_DABT;
    end else if (masked_s[EXC_FIQ]) begin
      grant = GNT_FIQ;
    end else if (masked_s[EXC_IRQ]) begin
      grant = GNT_IRQ;
    end else if (masked_s[EXC_PABT]) begin
      grant = GNT_PABT;
    end else if (masked_s[EXC_UND]) begin
      grant = GNT_UND;
    end else if (masked_s[EXC_SVC]) begin
      grant = GNT_SVC;
    end else begin
      grant = 6'b000000;
    end
  end

  assign valid = |masked_s;

endmodule

// File: rtl/exc_entry_ctrl.sv
// Exception entry sequencer: saves the return address and SPSR, then vectors
// the PC and updates the CPSR; otherwise forwards core register writes.
module exc_entry_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VBASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  exc_req,
  input  logic [31:0] exc_pc,
  input  logic [31:0] cpsr_in,
  input  logic        core_write_reg,
  input  logic [3:0]  core_w_addr,
  input  logic [31:0] core_w_data,
  input  logic        core_write_pc,
  input  logic [31:0] core_pc_data,
  output logic [4:0]  M,
  output logic        write_reg,
  output logic [3:0]  w_addr,
  output logic [31:0] w_data,
  output logic        write_pc,
  output logic [31:0] pc_data,
  output logic        spsr_we,
  output logic [31:0] spsr_data,
  output logic        cpsr_we,
  output logic [31:0] cpsr_data,
  output logic        busy,
  output logic        stall,
  output logic [5:0]  exc_ack
);

  exc_state_e  state_r, state_s;
  logic        armed_r;
  logic [5:0]  type_r;
  logic [31:0] pc_r, cpsr_r;
  logic [5:0]  grant_s;
  logic        valid_s, take_s;
  logic [4:0]  mode_s;
  logic [31:0] new_cpsr_s;

  logic [4:0]  m_s;
  logic        write_reg_s, write_pc_s, spsr_we_s, cpsr_we_s;
  logic [3:0]  w_addr_s;
  logic [31:0] w_data_s, pc_data_s, spsr_data_s, cpsr_data_s;
  logic [5:0]  exc_ack_s;

  exc_prio_enc u_prio (
    .req      (exc_req),
    .irq_mask (cpsr_in[7]),
    .fiq_mask (cpsr_in[6]),
    .grant    (grant_s),
    .valid    (valid_s)
  );

  // armed_r blocks request acceptance during the first cycle out of reset.
  assign take_s = armed_r & valid_s & (state_r == ST_IDLE);
  assign busy   = (state_r != ST_IDLE);
  assign stall  = busy | take_s;

  assign mode_s     = target_mode(type_r);
  assign new_cpsr_s = {cpsr_r[31:8], 1'b1, (type_r == GNT_FIQ) ? 1'b1 : cpsr_r[6], 1'b0, mode_s};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_s = ST_SAVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAVE:   state_s = ST_VECTOR;
      ST_VECTOR: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Capture the accepted exception's type, PC and CPSR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_r <= 1'b0;
      type_r  <= 6'b000000;
      pc_r    <= 32'h0000_0000;
      cpsr_r  <= 32'h0000_0000;
    end else begin
      armed_r <= 1'b1;
      if (take_s) begin
        type_r <= grant_s;
        pc_r   <= exc_pc;
        cpsr_r <= cpsr_in;
      end else begin
        type_r <= type_r;
        pc_r   <= pc_r;
        cpsr_r <= cpsr_r;
      end
    end
  end

  // Output decode per state; core writes are only forwarded from IDLE.
  always_comb begin
    m_s         = 5'd0;
    write_reg_s = 1'b0;
    w_addr_s    = 4'd0;
    w_data_s    = 32'h0000_0000;
    write_pc_s  = 1'b0;
    pc_data_s   = 32'h0000_0000;
    spsr_we_s   = 1'b0;
    spsr_data_s = 32'h0000_0000;
    cpsr_we_s   = 1'b0;
    cpsr_data_s = 32'h0000_0000;
    exc_ack_s   = 6'b000000;
    case (state_r)
      ST_IDLE: begin
        m_s         = cpsr_in[4:0];
        write_reg_s = core_write_reg;
        w_addr_s    = core_w_addr;
        w_data_s    = core_w_data;
        write_pc_s  = core_write_pc;
        pc_data_s   = core_pc_data;
      end
      ST_SAVE: begin
        m_s         = mode_s;
        write_reg_s = 1'b1;
        w_addr_s    = LR_ADDR;
        w_data_s    = pc_r + ret_offset(type_r);
        spsr_we_s   = 1'b1;
        spsr_data_s = cpsr_r;
      end
      ST_VECTOR: begin
        m_s         = mode_s;
        write_pc_s  = 1'b1;
        pc_data_s   = VBASE + vec_offset(type_r);
        cpsr_we_s   = 1'b1;
        cpsr_data_s = new_cpsr_s;
        exc_ack_s   = type_r;
      end
      default: begin
        m_s = 5'd0;
      end
    endcase
  end

  // Registered outputs, stable for the register file's negedge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      M         <= 5'd0;
      write_reg <= 1'b0;
      w_addr    <= 4'd0;
      w_data    <= 32'h0000_0000;
      write_pc  <= 1'b0;
      pc_data   <= 32'h0000_0000;
      spsr_we   <= 1'b0;
      spsr_data <= 32'h0000_0000;
      cpsr_we   <= 1'b0;
      cpsr_data <= 32'h0000_0000;
      exc_ack   <= 6'b000000;
    end else begin
      M         <= m_s;
      write_reg <= write_reg_s;
      w_addr    <= w_addr_s;
      w_data    <= w_data_s;
      write_pc  <= write_pc_s;
      pc_data   <= pc_data_s;
      spsr_we   <= spsr_we_s;
      spsr_data <= spsr_data_s;
      cpsr_we   <= cpsr_we_s;
      cpsr_data <= cpsr_data_s;
      exc_ack   <= exc_ack_s;
    end
  end

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Directed bench for exc_entry_ctrl: default VBASE instance plus a high-vector
// instance sharing the same stimulus.
module tb_exc_entry_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  exc_req;
  logic [31:0] exc_pc, cpsr_in;
  logic        core_write_reg, core_write_pc;
  logic [3:0]  core_w_addr;
  logic [31:0] core_w_data, core_pc_data;

  logic [4:0]  M, M_h;
  logic        write_reg, write_pc, spsr_we, cpsr_we, busy, stall;
  logic        write_reg_h, write_pc_h, spsr_we_h, cpsr_we_h, busy_h, stall_h;
  logic [3:0]  w_addr, w_addr_h;
  logic [31:0] w_data, pc_data, spsr_data, cpsr_data;
  logic [31:0] w_data_h, pc_data_h, spsr_data_h, cpsr_data_h;
  logic [5:0]  exc_ack, exc_ack_h;

  int pass_cnt = 0;
  int check_cnt = 0;

  exc_entry_ctrl u_dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_pc(exc_pc), .cpsr_in(cpsr_in),
    .core_write_reg(core_write_reg), .core_w_addr(core_w_addr), .core_w_data(core_w_data),
    .core_write_pc(core_write_pc), .core_pc_data(core_pc_data),
    .M(M), .write_reg(write_reg), .w_addr(w_addr), .w_data(w_data),
    .write_pc(write_pc), .pc_data(pc_data), .spsr_we(spsr_we), .spsr_data(spsr_data),
    .cpsr_we(cpsr_we), .cpsr_data(cpsr_data), .busy(busy), .stall(stall), .exc_ack(exc_ack)
  );

  exc_entry_ctrl #(.VBASE(32'hFFFF_0000)) u_hi (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_pc(exc_pc), .cpsr_in(cpsr_in),
    .core_write_reg(core_write_reg), .core_w_addr(core_w_addr), .core_w_data(core_w_data),
    .core_write_pc(core_write_pc), .core_pc_data(core_pc_data),
    .M(M_h), .write_reg(write_reg_h), .w_addr(w_addr_h), .w_data(w_data_h),
    .write_pc(write_pc_h), .pc_data(pc_data_h), .spsr_we(spsr_we_h), .spsr_data(spsr_data_h),
    .cpsr_we(cpsr_we_h), .cpsr_data(cpsr_data_h), .busy(busy_h), .stall(stall_h), .exc_ack(exc_ack_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; exc_req = 6'b000000; exc_pc = 32'h0; cpsr_in = 32'h0;
    core_write_reg = 1'b0; core_w_addr = 4'd0; core_w_data = 32'h0;
    core_write_pc = 1'b0; core_pc_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_write_reg", {31'd0, write_reg}, 32'd0);
    chk("rst_write_pc", {31'd0, write_pc}, 32'd0);
    chk("rst_spsr_we", {31'd0, spsr_we}, 32'd0);
    chk("rst_cpsr_we", {31'd0, cpsr_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ack", {26'd0, exc_ack}, 32'd0);

    // irq with I=0; first cycle after release must not accept it
    rst = 1'b1; cpsr_in = 32'h10; exc_pc = 32'h100; exc_req = 6'b000100;
    #1 chk("first_cycle_stall", {31'd0, stall}, 32'd0);
    step();
    chk("irq_pend_stall", {31'd0, stall}, 32'd1);
    chk("irq_pend_busy", {31'd0, busy}, 32'd0);
    chk("idle_M", {27'd0, M}, 32'h10);
    step();
    chk("irq_busy", {31'd0, busy}, 32'd1);
    chk("irq_stall", {31'd0, stall}, 32'd1);
    step();
    chk("irq_save_M", {27'd0, M}, 32'h12);
    chk("irq_save_wr", {31'd0, write_reg}, 32'd1);
    chk("irq_save_addr", {28'd0, w_addr}, 32'd14);
    chk("irq_save_data", w_data, 32'h104);
    chk("irq_save_spsr_we", {31'd0, spsr_we}, 32'd1);
    chk("irq_save_spsr", spsr_data, 32'h10);
    step();
    chk("irq_vec_wpc", {31'd0, write_pc}, 32'd1);
    chk("irq_vec_pc", pc_data, 32'h18);
    chk("irq_vec_cpsr_we", {31'd0, cpsr_we}, 32'd1);
    chk("irq_vec_cpsr", cpsr_data, 32'h92);
    chk("irq_vec_ack", {26'd0, exc_ack}, 32'h04);
    chk("irq_vec_wr", {31'd0, write_reg}, 32'd0);
    exc_req = 6'b000000; cpsr_in = 32'h92;
    step();
    chk("irq_ack_one_cycle", {26'd0, exc_ack}, 32'd0);
    chk("irq_after_wpc", {31'd0, write_pc}, 32'd0);
    chk("irq_after_M", {27'd0, M}, 32'h12);

    // masked irq: no stall, core writes pass through
    exc_req = 6'b000100; core_write_reg = 1'b1; core_w_addr = 4'd5; core_w_data = 32'hABCD;
    core_write_pc = 1'b1; core_pc_data = 32'h400;
    #1 chk("mask_stall", {31'd0, stall}, 32'd0);
    step();
    chk("mask_busy", {31'd0, busy}, 32'd0);
    chk("pass_wr", {31'd0, write_reg}, 32'd1);
    chk("pass_addr", {28'd0, w_addr}, 32'd5);
    chk("pass_data", w_data, 32'hABCD);
    chk("pass_wpc", {31'd0, write_pc}, 32'd1);
    chk("pass_pc", pc_data, 32'h400);
    chk("mask_spsr_we", {31'd0, spsr_we}, 32'd0);
    exc_req = 6'b000000; core_write_reg = 1'b0; core_write_pc = 1'b0;
    step();

    // dabt and fiq together: dabt first, fiq after return with F=0
    cpsr_in = 32'h10; exc_pc = 32'h200; exc_req = 6'b000011;
    step();
    chk("dabt_busy", {31'd0, busy}, 32'd1);
    step();
    chk("dabt_save_M", {27'd0, M}, 32'h17);
    chk("dabt_save_data", w_data, 32'h208);
    step();
    chk("dabt_vec_pc", pc_data, 32'h10);
    chk("dabt_vec_ack", {26'd0, exc_ack}, 32'h01);
    chk("dabt_vec_cpsr", cpsr_data, 32'h97);
    exc_req = 6'b000010; cpsr_in = 32'h97;
    #1 chk("fiq_pend_stall", {31'd0, stall}, 32'd1);
    step();
    step();
    chk("fiq_save_M", {27'd0, M}, 32'h11);
    chk("fiq_save_data", w_data, 32'h204);
    chk("fiq_save_spsr", spsr_data, 32'h97);
    step();
    chk("fiq_vec_pc", pc_data, 32'h1C);
    chk("fiq_vec_cpsr", cpsr_data, 32'hD1);
    chk("fiq_vec_ack", {26'd0, exc_ack}, 32'h02);
    exc_req = 6'b000000; cpsr_in = 32'hD1;
    step();
    exc_req = 6'b000010;
    #1 chk("fiq_masked_stall", {31'd0, stall}, 32'd0);
    step();
    chk("fiq_masked_busy", {31'd0, busy}, 32'd0);
    exc_req = 6'b000000;

    // svc with a core write of r3 in the same cycle
    cpsr_in = 32'h10; exc_pc = 32'h300; exc_req = 6'b100000;
    core_write_reg = 1'b1; core_w_addr = 4'd3; core_w_data = 32'h55;
    #1 chk("svc_stall", {31'd0, stall}, 32'd1);
    step();
    chk("svc_core_wr", {31'd0, write_reg}, 32'd1);
    chk("svc_core_addr", {28'd0, w_addr}, 32'd3);
    chk("svc_core_data", w_data, 32'h55);
    core_w_addr = 4'd7; core_w_data = 32'h77;
    step();
    chk("svc_save_M", {27'd0, M}, 32'h13);
    chk("svc_save_addr", {28'd0, w_addr}, 32'd14);
    chk("svc_save_data", w_data, 32'h304);
    step();
    chk("svc_drop_core_wr", {31'd0, write_reg}, 32'd0);
    chk("svc_vec_pc", pc_data, 32'h08);
    chk("svc_vec_ack", {26'd0, exc_ack}, 32'h20);
    chk("svc_vec_cpsr", cpsr_data, 32'h93);
    exc_req = 6'b000000; core_write_reg = 1'b0; cpsr_in = 32'h10;
    step();

    // und on both instances
    exc_pc = 32'h400; exc_req = 6'b010000;
    step();
    step();
    chk("und_save_M", {27'd0, M}, 32'h1B);
    chk("und_hi_save_M", {27'd0, M_h}, 32'h1B);
    chk("und_save_data", w_data, 32'h404);
    step();
    chk("und_vec_pc", pc_data, 32'h04);
    chk("und_hi_vec_pc", pc_data_h, 32'hFFFF_0004);
    chk("und_vec_cpsr", cpsr_data, 32'h9B);
    exc_req = 6'b000000;
    step();

    // reset asserted while SAVE outputs are on the bus
    exc_pc = 32'h500; exc_req = 6'b001000;
    step();
    step();
    chk("pabt_save_spsr_we", {31'd0, spsr_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_spsr_we", {31'd0, spsr_we}, 32'd0);
    chk("abort_write_reg", {31'd0, write_reg}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b1;
    #1 chk("abort_first_stall", {31'd0, stall}, 32'd0);
    step();
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_ack", {26'd0, exc_ack}, 32'd0);
    chk("abort_no_wpc", {31'd0, write_pc}, 32'd0);
    exc_req = 6'b000000;
    step();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
